mem_sti_arb: RTL and testbench

Two-port request arbiter and STI master sitting directly upstream of the serial-SRAM main memory controller. It merges the instruction-fetch port and the data (MAR/MDR) port of the LC-3 datapath onto the single STI slave interface (`init_txn`/`wtxn`/`addr`/`wdata`/`rdata`/`rdy`). It runs one STI transaction at a time, round-robin between ports, and returns read data with a one-cycle acknowledge.

---
 rtl/mem_sti_arb.sv | 193 +++++++++++++++++++
 tb/tb_mem_sti_arb.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sti_arb.sv
// mem_sti_arb: two-port round-robin arbiter and STI master for the serial-SRAM
// controller. Port 0 is instruction fetch and port 1 is data (MAR/MDR).
// Only one STI transaction is in flight at a time. Read data comes back with a
// one-cycle ack to the port that was granted.
// Optional build macro MEM_STI_ARB_WDOG_EN adds a BUSY watchdog. When it fires,
// the arbiter returns 16'hDEAD, sets the sticky err flag and still acks the port.
module mem_sti_arb #(
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [15:0] p0_addr,
    input  logic [15:0] p0_wdata,
    output logic        p0_ack,
    output logic [15:0] p0_rdata,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [15:0] p1_addr,
    input  logic [15:0] p1_wdata,
    output logic        p1_ack,
    output logic [15:0] p1_rdata,
    output logic        init_txn,
    output logic        wtxn,
    output logic [15:0] addr,
    output logic [15:0] wdata,
    input  logic [15:0] rdata,
    input  logic        rdy,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_init_txn;
    logic        r_wtxn;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [1:0]  r_ack;
    logic        r_gnt;
    logic        r_last;
    logic        r_busy_first;

    // Pack both ports into arrays so that the winner can be selected by index.
    logic [1:0]  w_req;
    logic [1:0]  w_we;
    logic [15:0] w_addr  [2];
    logic [15:0] w_wdata [2];

    assign w_req      = {p1_req, p0_req};
    assign w_we       = {p1_we, p0_we};
    assign w_addr[0]  = p0_addr;
    assign w_addr[1]  = p1_addr;
    assign w_wdata[0] = p0_wdata;
    assign w_wdata[1] = p1_wdata;

    // On a tie, the port that did not complete last wins.
    // A single requester always wins.
    logic w_win;
    assign w_win = (w_req == 2'b11) ? ~r_last : w_req[1];

    // rdy is ignored in the first BUSY cycle. The slave may not have seen
    // init_txn yet, so rdy can still be high from before.
    logic w_busy_done;
    assign w_busy_done = (r_state == S_BUSY) && !r_busy_first && rdy;

    logic w_wdog_fire;

`ifdef MEM_STI_ARB_WDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_wdog_cnt;
    logic          r_err;

    assign w_wdog_fire = (r_state == S_BUSY) && !w_busy_done && (r_wdog_cnt == CNT_LAST);
    assign err         = r_err;

    // Count BUSY cycles. The count restarts on every entry to BUSY.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog_cnt <= '0;
        end else if (r_state == S_ISSUE) begin
            r_wdog_cnt <= '0;
        end else if (r_state == S_BUSY && !w_wdog_fire) begin
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
        end
    end

    // Sticky error flag. Only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_wdog_fire) begin
            r_err <= 1'b1;
        end
    end
`else
    // TIMEOUT has no effect without the watchdog. It is kept so that both builds
    // share the same parameter list.
    logic w_unused_cfg;
    assign w_unused_cfg = (TIMEOUT != 0);
    assign w_wdog_fire  = 1'b0;
    assign err          = 1'b0;
`endif

    // Return data that goes into the granted port's return register.
    logic        w_capture;
    logic [15:0] w_ret;
    assign w_capture = w_busy_done || w_wdog_fire;
    assign w_ret     = w_busy_done ? rdata : 16'hDEAD;

    // One return register per port. Each register holds its value until the
    // next DONE for that port.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [15:0] r_rdata;

            // Capture the return data when the granted transaction completes.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rdata <= '0;
                end else if (w_capture && (r_gnt == gi[0])) begin
                    r_rdata <= w_ret;
                end
            end
        end
    endgenerate

    assign p0_rdata = g_port[0].r_rdata;
    assign p1_rdata = g_port[1].r_rdata;

    // Transaction FSM. It owns every registered STI output and both acks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_init_txn   <= 1'b0;
            r_wtxn       <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_ack        <= '0;
            r_gnt        <= 1'b0;
            r_last       <= 1'b1;
            r_busy_first <= 1'b0;
        end else begin
            r_init_txn <= 1'b0;
            r_ack      <= '0;
            case (r_state)
                S_IDLE: begin
                    if (rdy && (|w_req)) begin
                        r_gnt      <= w_win;
                        r_wtxn     <= w_we[w_win];
                        r_addr     <= w_addr[w_win];
                        r_wdata    <= w_wdata[w_win];
                        r_init_txn <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_busy_first <= 1'b1;
                    r_state      <= S_BUSY;
                end
                S_BUSY: begin
                    r_busy_first <= 1'b0;
                    if (w_capture) begin
                        r_ack[r_gnt] <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_last  <= r_gnt;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign init_txn = r_init_txn;
    assign wtxn     = r_wtxn;
    assign addr     = r_addr;
    assign wdata    = r_wdata;
    assign p0_ack   = r_ack[0];
    assign p1_ack   = r_ack[1];

endmodule

// File: tb/tb_mem_sti_arb.sv
// Testbench for mem_sti_arb. Directed scenarios are followed by a randomized phase.
// The reference model is transaction level: it tracks per-port masters, a
// memory-backed STI slave, the round-robin "last" port and the outstanding
// transaction. From these it predicts init_txn, the acks, the return data and err.
module tb_mem_sti_arb;

    localparam int TMO = 15;
`ifdef MEM_STI_ARB_WDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_ack, p1_ack;
    logic [15:0] p0_rdata, p1_rdata;
    logic        init_txn, wtxn;
    logic [15:0] addr, wdata, rdata;
    logic        rdy;
    logic        err;

    always #5 clk = ~clk;

    mem_sti_arb #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .init_txn(init_txn), .wtxn(wtxn), .addr(addr), .wdata(wdata),
        .rdata(rdata), .rdy(rdy), .err(err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Master model, one entry per port
    bit          mst_act   [2];
    bit          mst_we    [2];
    logic [15:0] mst_addr  [2];
    logic [15:0] mst_wdata [2];

    // Slave memory and arbiter-level reference state
    logic [15:0] mem [logic [15:0]];
    int          m_out;          // port with a transaction in flight, -1 if none
    bit          m_last;
    logic [15:0] m_rdata [2];
    bit          m_err;
    int          age, lat;
    logic [15:0] ret;
    bit          exp_init;
    bit          exp_win;
    int          exp_ack;
    int          n_done = 0;
    logic [15:0] obs_q[$];

    // Knobs
    bit rand_mode = 0;
    bit b2b_all   = 0;
    bit hang      = 0;
    bit want_rst  = 0;
    int lat_lo = 1, lat_hi = 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 16'hA5C3;
    endfunction

    task automatic set_req(input int p, input bit we, input logic [15:0] a, input logic [15:0] d);
        mst_act[p] = 1; mst_we[p] = we; mst_addr[p] = a; mst_wdata[p] = d;
    endtask

    // Random request. Address bit 15 carries the port number so that grants can be read from addr.
    task automatic new_rand(input int p);
        set_req(p, 1'($urandom), {p[0], 11'd0, 4'($urandom)}, 16'($urandom));
    endtask

    task automatic model_reset();
        m_out = -1; m_last = 1; m_err = 0;
        m_rdata[0] = '0; m_rdata[1] = '0;
        mst_act[0] = 0; mst_act[1] = 0;
        exp_init = 0; exp_ack = -1;
    endtask

    // One clock: check outputs against predictions, advance the model, drive inputs and predict the next cycle.
    task automatic cycle();
        bit rst_edge, ack_now, inited;
        int p;
        rst_edge = rst; ack_now = 0; inited = 0;
        @(posedge clk); #1;
        if (rst_edge) begin
            model_reset();
            chk("rst_ctl", {27'd0, init_txn, wtxn, p0_ack, p1_ack, err}, 32'd0);
            chk("rst_addr", addr, 0);
            chk("rst_wdata", wdata, 0);
            chk("rst_rdata0", p0_rdata, 0);
            chk("rst_rdata1", p1_rdata, 0);
        end else begin
            chk("init_txn", init_txn, exp_init);
            chk("p0_ack", p0_ack, exp_ack == 0);
            chk("p1_ack", p1_ack, exp_ack == 1);
            chk("err", err, m_err);
            if (exp_ack >= 0) m_rdata[exp_ack] = ret;
            chk("p0_rdata", p0_rdata, m_rdata[0]);
            chk("p1_rdata", p1_rdata, m_rdata[1]);
            if (exp_init) begin
                inited = 1; p = exp_win;
                chk("sti_addr", addr, mst_addr[p]);
                chk("sti_wtxn", wtxn, mst_we[p]);
                chk("sti_wdata", wdata, mst_wdata[p]);
                obs_q.push_back(addr);
                m_out = p; age = 0; lat = $urandom_range(lat_hi, lat_lo);
                if (mst_we[p]) begin
                    mem[mst_addr[p]] = mst_wdata[p];
                    ret = 16'($urandom);
                end else begin
                    ret = mem_rd(mst_addr[p]);
                end
            end
            if (exp_ack >= 0) begin
                p = exp_ack; ack_now = 1; m_last = p[0]; m_out = -1; n_done++;
                $display("txn %0d: port %0d %s addr=%h data=%h", n_done, p,
                         mst_we[p] ? "WR" : "RD", mst_addr[p], mst_we[p] ? mst_wdata[p] : ret);
                if (b2b_all || (rand_mode && $urandom_range(2, 0) == 0)) new_rand(p);
                else mst_act[p] = 0;
            end
        end
        // Drive inputs for this cycle
        rst = want_rst; want_rst = 0;
        if (m_out >= 0) begin
            if (!inited) age++;
            rdy   = !hang && (age >= lat);
            rdata = ret;
        end else begin
            rdy   = rand_mode ? ($urandom_range(4, 0) != 0) : 1'b1;
            rdata = 16'($urandom);
        end
        if (rand_mode)
            for (int q = 0; q < 2; q++)
                if (!mst_act[q] && $urandom_range(3, 0) == 0) new_rand(q);
        p0_req = mst_act[0]; p0_we = mst_we[0]; p0_addr = mst_addr[0]; p0_wdata = mst_wdata[0];
        p1_req = mst_act[1]; p1_we = mst_we[1]; p1_addr = mst_addr[1]; p1_wdata = mst_wdata[1];
        // Predict what the next edge produces
        exp_ack = -1; exp_init = 0;
        if (!rst) begin
            if (m_out >= 0 && !inited) begin
                if (age >= 2 && rdy) exp_ack = m_out;
                else if (WDOG && age >= TMO) begin
                    exp_ack = m_out; ret = 16'hDEAD; m_err = 1;
                end
            end else if (m_out < 0 && !ack_now && rdy && (mst_act[0] || mst_act[1])) begin
                exp_init = 1;
                exp_win  = (mst_act[0] && mst_act[1]) ? !m_last : mst_act[1];
            end
        end
    endtask

    task automatic run_until(input int target, input int maxc, input string tag);
        int c = 0;
        while (n_done < target && c < maxc) begin cycle(); c++; end
        chk(tag, n_done >= target, 1);
    endtask

    task automatic drain(input int maxc);
        int c = 0;
        while ((mst_act[0] || mst_act[1] || m_out >= 0) && c < maxc) begin cycle(); c++; end
        chk("drain", {mst_act[0], mst_act[1], m_out >= 0}, 0);
    endtask

    task automatic wait_age(input int a, input int maxc);
        int c = 0;
        while (!(m_out >= 0 && age == a) && c < maxc) begin cycle(); c++; end
        chk("wait_busy", age, a);
    endtask

    task automatic do_reset();
        want_rst = 1;
        cycle();
        cycle();
    endtask

    initial begin
        rst = 1; rdy = 1; rdata = '0;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        for (int p = 0; p < 2; p++) begin mst_we[p] = 0; mst_addr[p] = '0; mst_wdata[p] = '0; end
        model_reset();
        cycle();
        cycle();

        // Read on port 0. The slave answers after 20 cycles.
        mem[16'h3000] = 16'h1234;
        lat_lo = 20; lat_hi = 20;
        set_req(0, 0, 16'h3000, 16'h0000);
        run_until(n_done + 1, 60, "rd_p0_done");
        chk("rd_p0_rdata", p0_rdata, 16'h1234);

        // Write on port 1. Port 0's return data must not change. Then read the word back.
        lat_lo = 5; lat_hi = 5;
        set_req(1, 1, 16'h8001, 16'hBEEF);
        run_until(n_done + 1, 40, "wr_p1_done");
        chk("wr_p1_keep_p0", p0_rdata, 16'h1234);
        set_req(0, 0, 16'h8001, 16'h0000);
        run_until(n_done + 1, 40, "rd_back_done");
        chk("rd_back", p0_rdata, 16'hBEEF);

        // Round-robin from reset with both ports requesting back-to-back
        do_reset();
        obs_q.delete();
        lat_lo = 3; lat_hi = 3;
        new_rand(0); new_rand(1); b2b_all = 1;
        run_until(n_done + 4, 100, "rr_run");
        b2b_all = 0;
        drain(100);
        chk("rr_count", obs_q.size() >= 4, 1);
        for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), obs_q[i][15], i % 2);

        // Late arrival: port 1 raises its request while port 0 is in BUSY
        lat_lo = 12; lat_hi = 12;
        set_req(0, 0, 16'h0042, 16'h0000);
        wait_age(5, 20);
        set_req(1, 0, 16'h8042, 16'h0000);
        run_until(n_done + 2, 80, "late_done");

        // Reset in the middle of BUSY, then a fresh request
        lat_lo = 30; lat_hi = 30;
        set_req(0, 0, 16'h0100, 16'h0000);
        wait_age(5, 20);
        do_reset();
        lat_lo = 4; lat_hi = 4;
        set_req(1, 0, 16'h8100, 16'h0000);
        run_until(n_done + 1, 40, "post_rst_done");

`ifdef MEM_STI_ARB_WDOG_EN
        // Watchdog: the slave never becomes ready
        hang = 1;
        set_req(0, 0, 16'h0007, 16'h0000);
        run_until(n_done + 1, 40, "wdog_done");
        chk("wdog_rdata", p0_rdata, 16'hDEAD);
        chk("wdog_err", err, 1);
        hang = 0;
        lat_lo = 3; lat_hi = 3;
        set_req(0, 0, 16'h0008, 16'h0000);
        run_until(n_done + 1, 40, "wdog_next_done");
        chk("wdog_err_sticky", err, 1);
`endif

        // Randomized traffic
        rand_mode = 1; lat_lo = 1; lat_hi = 12;
        run_until(n_done + 150, 20000, "random_run");
        rand_mode = 0;
        drain(200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard stop in case the run never reaches the end of the stimulus
    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "global timeout");
    end

endmodule
